// File: rtl/pwm_sar_scheduler.sv
// pwm_sar_scheduler: round-robin SAR conversion scheduler with mux settling, averaging and timeout
module pwm_sar_scheduler #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int SETTLE_CYCLES = 1000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [NUM_CH-1:0]          ch_enable_mask,
  input  logic                       sar_done,
  input  logic [WIDTH-1:0]           sar_result,
  output logic                       sar_enable,
  output logic [$clog2(NUM_CH)-1:0]  mux_sel,
  output logic [WIDTH-1:0]           result_data,
  output logic [$clog2(NUM_CH)-1:0]  result_ch,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int SETTLE_EFF = SETTLE_CYCLES < 1 ? 1 : SETTLE_CYCLES;
  localparam int SW = $clog2(SETTLE_EFF + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONVERT, GAP, PUBLISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] last_ch, pick_ch, idx;
  logic pick_ok;
  logic [AW-1:0] acc, acc_n;
  logic [NW-1:0] cnt, cnt_n;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic settled, timed_out, sample_done, last_sample, abandon;
  // Descending search so the nearest enabled channel after last_ch wins
  always_comb begin
    pick_ch = '0;
    pick_ok = 1'b0;
    idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = CW'((int'(last_ch) + k) % NUM_CH);
      if (ch_enable_mask[idx]) begin
        pick_ch = idx;
        pick_ok = 1'b1;
      end
    end
  end
  assign settled = settle_cnt == SW'(SETTLE_EFF - 1);
  assign timed_out = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign sample_done = state == CONVERT && sar_done;
  assign abandon = state == CONVERT && !sar_done && timed_out;
  assign acc_n = acc + AW'(sar_result);
  assign cnt_n = cnt + NW'(1);
  assign last_sample = cnt_n == NW'(2 ** AVG_LOG2);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = run && |ch_enable_mask ? SELECT : IDLE;
      SELECT:  state_n = pick_ok ? SETTLE : IDLE;
      SETTLE:  state_n = settled ? CONVERT : SETTLE;
      CONVERT: state_n = sar_done ? (last_sample ? PUBLISH : GAP) : timed_out ? (run ? SELECT : IDLE) : CONVERT;
      GAP:     state_n = CONVERT;
      PUBLISH: state_n = run ? SELECT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_ch <= CW'(NUM_CH - 1);
      mux_sel <= '0;
      acc <= '0;
      cnt <= '0;
      settle_cnt <= '0;
      tmo_cnt <= '0;
      sar_enable <= 1'b0;
      result_data <= '0;
      result_ch <= '0;
      result_valid <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      sar_enable <= state_n == CONVERT;
      busy <= state_n != IDLE;
      result_valid <= state_n == PUBLISH;
      settle_cnt <= state == SETTLE ? settle_cnt + SW'(1) : '0;
      tmo_cnt <= state == CONVERT ? tmo_cnt + TW'(1) : '0;
      if (state == SELECT && pick_ok) begin
        mux_sel <= pick_ch;
        acc <= '0;
        cnt <= '0;
      end
      if (sample_done) begin
        acc <= acc_n;
        cnt <= cnt_n;
      end
      if (sample_done && last_sample) begin
        result_data <= WIDTH'(acc_n >> AVG_LOG2);
        result_ch <= mux_sel;
      end
      if (state == PUBLISH || abandon) last_ch <= mux_sel;
      if (abandon) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pwm_sar_scheduler.sv
// tb_pwm_sar_scheduler: transaction-level model of scan order, averaging and timeout, checked every cycle
module tb_pwm_sar_scheduler;
  logic clk = 0, reset = 1, run = 0, sar_done = 0;
  logic [3:0] mask = 0;
  logic [7:0] sar_result = 0;
  logic sar_enable, result_valid, busy, timeout_err;
  logic [1:0] mux_sel, result_ch;
  logic [7:0] result_data;

  pwm_sar_scheduler #(.WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(4), .AVG_LOG2(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .run(run), .ch_enable_mask(mask), .sar_done(sar_done),
    .sar_result(sar_result), .sar_enable(sar_enable), .mux_sel(mux_sel), .result_data(result_data),
    .result_ch(result_ch), .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int mode = 0, stall = 0, spur = 0;
  int en_cnt = 0, m_ch = 0, m_last = 3, m_n = 0, m_sum = 0, m_tmo = 0;
  int pub_due = 0, low_due = 0, exp_ch = 0, exp_d = 0, held_ch = 0, held_d = 0;
  int pub_ch[$], pub_d[$], pub_t[$];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rr(int last, logic [3:0] m);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (m[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  function automatic int val(int ch, int i);
    if (mode == 1) return 255;
    if (mode == 2) return i == 3 ? 3 : 0;
    return 64 + 16 * ch + i;
  endfunction

  // SAR engine model plus scoreboard; compares first, then advances the model
  always @(negedge clk) begin
    int v;
    cyc++;
    if (sar_enable && en_cnt == 0 && m_n == 0) m_ch = rr(m_last, mask);
    check("result_valid", int'(result_valid), pub_due);
    if (pub_due != 0) begin
      check("publish_ch", int'(result_ch), exp_ch);
      check("publish_data", int'(result_data), exp_d);
      held_ch = exp_ch;
      held_d = exp_d;
    end else begin
      check("hold_ch", int'(result_ch), held_ch);
      check("hold_data", int'(result_data), held_d);
    end
    if (result_valid) begin
      pub_ch.push_back(int'(result_ch));
      pub_d.push_back(int'(result_data));
      pub_t.push_back(cyc);
    end
    check("timeout_err", int'(timeout_err), m_tmo);
    if (sar_enable) begin
      check("mux_sel", int'(mux_sel), m_ch);
      check("busy_in_convert", int'(busy), 1);
    end
    if (low_due != 0) check("enable_drop", int'(sar_enable), 0);
    pub_due = 0;
    low_due = 0;
    sar_done = 0;
    if (reset) begin
      en_cnt = 0; m_last = 3; m_n = 0; m_sum = 0; m_tmo = 0; held_ch = 0; held_d = 0;
    end else begin
      en_cnt = sar_enable ? en_cnt + 1 : 0;
      if (sar_enable && en_cnt == 10 && !(stall != 0 && m_ch == 2)) begin
        v = val(m_ch, m_n);
        sar_done = 1;
        sar_result = 8'(v);
        m_sum += v;
        m_n++;
        low_due = 1;
        if (m_n == 4) begin
          exp_ch = m_ch; exp_d = m_sum / 4; pub_due = 1;
          m_last = m_ch; m_n = 0; m_sum = 0;
        end
      end else if (sar_enable && en_cnt == 64) begin
        m_tmo = 1; m_last = m_ch; m_n = 0; m_sum = 0; low_due = 1;
      end else if (spur != 0 && !sar_enable && cyc % 2 == 1) begin
        sar_done = 1;
        sar_result = 8'hEE;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pubs(int n, int budget);
    int t = 0;
    while (pub_ch.size() < n && t < budget) begin tick(1); t++; end
    check("wait_pubs", pub_ch.size(), n);
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (busy && t < budget) begin tick(1); t++; end
    check("wait_idle", int'(busy), 0);
  endtask

  task automatic restart();
    run = 0;
    wait_idle(600);
    reset = 1;
    tick(2);
    reset = 0;
    pub_ch.delete(); pub_d.delete(); pub_t.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_sar_enable"}, int'(sar_enable), 0);
    check({tag, "_mux_sel"}, int'(mux_sel), 0);
    check({tag, "_result_data"}, int'(result_data), 0);
    check({tag, "_result_ch"}, int'(result_ch), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    tick(3);
    check_reset_outputs("rst");
    reset = 0;
    // full mask: ch0..ch3 then ch0, 49 cycles apart
    mask = 4'b1111; run = 1;
    wait_pubs(5, 400);
    if (pub_ch.size() >= 5) begin
      check("t1_order0", pub_ch[0], 0); check("t1_order1", pub_ch[1], 1);
      check("t1_order2", pub_ch[2], 2); check("t1_order3", pub_ch[3], 3);
      check("t1_order4", pub_ch[4], 0);
      check("t1_ch0_avg", pub_d[0], 8'h41); check("t1_ch1_avg", pub_d[1], 8'h51);
      check("t1_ch3_avg", pub_d[3], 8'h71);
      for (int i = 0; i < 4; i++) check("t1_spacing", pub_t[i+1] - pub_t[i], 49);
    end
    // alternate ch1/ch3, then mask narrowed to ch0 during ch3
    restart();
    mask = 4'b1010; run = 1;
    wait_pubs(3, 300);
    tick(30);
    check("t2_mid_convert", int'(sar_enable), 1);
    mask = 4'b0001;
    wait_pubs(6, 300);
    if (pub_ch.size() >= 6) begin
      check("t2_order0", pub_ch[0], 1); check("t2_order1", pub_ch[1], 3);
      check("t2_order2", pub_ch[2], 1); check("t2_order3", pub_ch[3], 3);
      check("t2_order4", pub_ch[4], 0); check("t2_order5", pub_ch[5], 0);
      check("t2_ch0_avg", pub_d[5], 8'h41);
    end
    // saturation and truncation
    restart();
    mode = 1; mask = 4'b0001; run = 1;
    wait_pubs(1, 200);
    mode = 2;
    wait_pubs(2, 200);
    if (pub_ch.size() >= 2) begin
      check("t3_all_ff", pub_d[0], 8'hFF);
      check("t3_truncate", pub_d[1], 8'h00);
    end
    // ch2 never answers: timeout, skip to ch3, sticky error
    restart();
    mode = 0; mask = 4'b1111; stall = 1; run = 1;
    wait_pubs(4, 600);
    if (pub_ch.size() >= 4) begin
      check("t4_order0", pub_ch[0], 0); check("t4_order1", pub_ch[1], 1);
      check("t4_order2", pub_ch[2], 3); check("t4_order3", pub_ch[3], 0);
      check("t4_skip_time", pub_t[2] - pub_t[1], 118);
    end
    check("t4_sticky", int'(timeout_err), 1);
    stall = 0;
    // run dropped during ch1 settle, with spurious done pulses
    restart();
    check("t5_err_cleared", int'(timeout_err), 0);
    mask = 4'b1111; run = 1;
    wait_pubs(1, 200);
    tick(2);
    run = 0; spur = 1;
    wait_idle(200);
    check("t5_pub_count", pub_ch.size(), 2);
    if (pub_ch.size() >= 2) begin
      check("t5_ch1", pub_ch[1], 1);
      check("t5_ch1_avg", pub_d[1], 8'h51);
    end
    tick(20);
    check("t5_idle_busy", int'(busy), 0);
    check("t5_idle_enable", int'(sar_enable), 0);
    check("t5_no_extra_pub", pub_ch.size(), 2);
    spur = 0;
    // reset during third conversion of ch0
    restart();
    run = 1;
    tick(32);
    check("t6_in_convert", int'(sar_enable), 1);
    reset = 1;
    tick(1);
    check_reset_outputs("t6");
    reset = 0;
    pub_ch.delete(); pub_d.delete(); pub_t.delete();
    wait_pubs(1, 200);
    if (pub_ch.size() >= 1) begin
      check("t6_restart_ch", pub_ch[0], 0);
      check("t6_fresh_avg", pub_d[0], 8'h41);
    end
    run = 0;
    wait_idle(200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_sar_scheduler.md
# pwm_sar_scheduler

Multi-channel conversion scheduler for the PWM SAR ADC. It time-shares the single SAR engine and comparator among up to NUM_CH analog inputs through an external analog mux. It also waits out PWM/RC-filter settling after each mux switch, averages 2^AVG_LOG2 conversions per channel, and publishes one averaged result per channel with a valid strobe. It sits between the SAR engine (which it enables and reads) and the display/readout logic (which consumes its per-channel results).

## Interface
Parameters:
- WIDTH, 8: SAR result width.
- NUM_CH, 4: number of mux channels, 2..8.
- SETTLE_CYCLES, 1000: clock cycles waited after a mux switch; a value of 0 is treated as 1.
- AVG_LOG2, 2: log2 of the number of samples averaged per channel (0..4).
- TIMEOUT_CYCLES, 4096: maximum number of cycles `sar_enable` may be high without `sar_done`.

Ports (CW = $clog2(NUM_CH)):
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; high = scan continuously.
- ch_enable_mask  in  NUM_CH  bit i set = channel i is included in the scan.
- sar_done  in  1  one-cycle pulse from the SAR engine when a conversion finishes.
- sar_result  in  WIDTH  SAR final code; valid in the cycle `sar_done` is high.
- sar_enable  out  1  held high for the whole conversion; low returns the SAR to its start state.
- mux_sel  out  CW  analog mux channel select.
- result_data  out  WIDTH  averaged code of the most recently published channel.
- result_ch  out  CW  channel number belonging to `result_data`.
- result_valid  out  1  one-cycle publish strobe.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on a SAR timeout, cleared only by reset.

## Operation
- States: IDLE, SELECT, SETTLE, CONVERT, GAP, PUBLISH.
- IDLE: if `run` is high and the mask is nonzero, go to SELECT; otherwise stay in IDLE.
- SELECT (1 cycle): choose the next enabled channel in round-robin order, searching from last_ch+1 with wrap-around.
  - last_ch resets to NUM_CH-1, so channel 0 goes first.
  - The mask is sampled only in SELECT. If it reads zero here, go to IDLE.
  - Load `mux_sel`, clear the accumulator and sample count, then go to SETTLE.
- SETTLE: count max(SETTLE_CYCLES,1) cycles, then go to CONVERT.
- CONVERT: `sar_enable` is high.
  - On `sar_done`: accumulator += `sar_result` and sample count += 1.
  - If count reaches 2^AVG_LOG2, go to PUBLISH; otherwise go to GAP.
  - If TIMEOUT_CYCLES elapse without `sar_done`: set `timeout_err`, discard the channel without publishing, update last_ch, and go to SELECT (or IDLE if `run` is low).
- GAP (1 cycle): `sar_enable` is low so the SAR restarts. Return to CONVERT; the mux does not change and there is no re-settle.
- PUBLISH (1 cycle):
  - `result_data` = accumulator >> AVG_LOG2 (truncating); `result_ch` = channel; `result_valid` = 1.
  - last_ch = channel.
  - Go to SELECT if `run` is high, otherwise IDLE.
- Accumulator width is WIDTH+AVG_LOG2 bits, so it cannot overflow.
- `run` falling mid-channel: the current channel completes and publishes, then the block goes to IDLE. There is no abort.
- `sar_done` is ignored in every state except CONVERT.
- Mask changes outside SELECT take effect at the next SELECT.
- A single enabled channel is rescanned every pass, with a full SETTLE each time.

## Timing
- Reset values: `sar_enable` 0, `mux_sel` 0, `result_data` 0, `result_ch` 0, `result_valid` 0, `busy` 0, `timeout_err` 0. State = IDLE, last_ch = NUM_CH-1.
- All outputs are registered.
- `mux_sel` changes in the first SETTLE cycle and is stable through PUBLISH.
- `sar_enable` rises in the first CONVERT cycle and falls in the cycle after `sar_done` is accepted.
- Per-channel latency, with Tc = SAR conversion time (cycles from `sar_enable` high to `sar_done`) and N = 2^AVG_LOG2: 1 (SELECT) + SETTLE + N·(Tc+1) cycles. The GAP after the last sample is replaced by PUBLISH.
- `result_valid` is exactly one cycle. `result_data` and `result_ch` hold until the next publish.
- Reset asserted mid-operation: in the next cycle all outputs are at their reset values and the partial accumulation is lost.

## Test plan
(Parameters for all scenarios: NUM_CH=4, SETTLE_CYCLES=4, AVG_LOG2=2, TIMEOUT_CYCLES=64. The SAR model returns `sar_done` 10 cycles after `sar_enable` rises.)
- Mask 4'b1111, `run`=1, SAR returns 0x40,0x41,0x42,0x43 on ch0 → one publish with ch0=0x41. Publishes follow in order ch0,ch1,ch2,ch3,ch0, spaced exactly 1+4+4·11 cycles apart.
- Mask 4'b1010 → publishes alternate ch1,ch3,ch1. Mask switched to 4'b0001 mid-ch3 conversion → ch3 completes, then ch0 only.
- SAR returns 0xFF for all four samples → `result_data`=0xFF with no overflow. Samples 0x00,0x00,0x00,0x03 → 0x00 (truncation).
- SAR model never pulses `sar_done` on ch2 → `timeout_err` set after 64 cycles, no publish for ch2, scan continues with ch3. `timeout_err` stays set until reset.
- `run` deasserted during SETTLE of ch1 → ch1 publishes, then `busy`=0 and `sar_enable`=0. Spurious `sar_done` pulses in IDLE, SETTLE and GAP are ignored.
- Reset pulsed during the third CONVERT of ch0 → all outputs at reset values the next cycle. After reset, scan restarts at ch0 with a fresh accumulator.
